// File: rtl/conv1_pkg.sv
// Shared widths, limits and types for the conv1 compute stage.
// The optional ReLU (macro CONV1_CALC_RELU_EN) lives in conv1_round_sat.
package conv1_pkg;

  localparam int DATA_BITS   = 32;
  localparam int FRAC_BITS   = 16;
  localparam int KERNEL_TAPS = 9;
  localparam int KERNEL_ROWS = 3;
  localparam int OUT_PIXELS  = 676;

  // Growth: one product doubles the width, a 3-term row sum adds 2 bits,
  // and the 3 rows plus bias plus rounding constant add 2 more.
  localparam int PROD_W = 2 * DATA_BITS;
  localparam int SUM_W  = 2 * DATA_BITS + 2;
  localparam int TOT_W  = 2 * DATA_BITS + 4;
  localparam int PIX_W  = $clog2(OUT_PIXELS);

  localparam logic [3:0] BIAS_BEAT = 4'd9;
  localparam logic [3:0] LOAD_DONE = 4'd10;

  localparam logic signed [DATA_BITS-1:0] SAT_MAX = {1'b0, {(DATA_BITS-1){1'b1}}};
  localparam logic signed [DATA_BITS-1:0] SAT_MIN = {1'b1, {(DATA_BITS-1){1'b0}}};

  typedef logic signed [DATA_BITS-1:0] window_t [KERNEL_TAPS];

endpackage

// File: rtl/conv1_round_sat.sv
// Combinational final stage: add row sums and bias, round to nearest, drop FRAC_BITS, saturate.
// Defining CONV1_CALC_RELU_EN clamps negative saturated results to zero.
module conv1_round_sat
  import conv1_pkg::*;
(
  input  logic signed [SUM_W-1:0]     row_sum [KERNEL_ROWS],
  input  logic signed [DATA_BITS-1:0] bias,
  output logic signed [DATA_BITS-1:0] result
);

  localparam logic signed [TOT_W-1:0] HALF =
    {{(TOT_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  function automatic logic signed [TOT_W-1:0] round_shift(input logic signed [TOT_W-1:0] total);
    return (total + HALF) >>> FRAC_BITS;
  endfunction

  function automatic logic signed [DATA_BITS-1:0] saturate(input logic signed [TOT_W-1:0] v);
    if (v > TOT_W'(SAT_MAX)) return SAT_MAX;
    if (v < TOT_W'(SAT_MIN)) return SAT_MIN;
    return v[DATA_BITS-1:0];
  endfunction

`ifdef CONV1_CALC_RELU_EN
  function automatic logic signed [DATA_BITS-1:0] relu(input logic signed [DATA_BITS-1:0] v);
    return v[DATA_BITS-1] ? '0 : v;
  endfunction
`endif

  logic signed [TOT_W-1:0]     total;
  logic signed [DATA_BITS-1:0] sat;

  always_comb begin
    // Bias is a Q-format value; align it with the Q(2*FRAC_BITS) products.
    total = TOT_W'(bias) <<< FRAC_BITS;
    for (int r = 0; r < KERNEL_ROWS; r++) begin
      total = total + TOT_W'(row_sum[r]);
    end
    sat = saturate(round_shift(total));
`ifdef CONV1_CALC_RELU_EN
    result = relu(sat);
`else
    result = sat;
`endif
  end

endmodule

// File: rtl/conv1_calc.sv
// conv1 compute stage: 3x3 window x kernel + bias, round/saturate, 3-cycle pipeline, map done pulse.
// Optional ReLU is selected with the CONV1_CALC_RELU_EN macro (see conv1_round_sat).
module conv1_calc
  import conv1_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DATA_BITS-1:0] data_in [KERNEL_TAPS],
  input  logic                        valid_in,
  input  logic                        w_load_en,
  input  logic signed [DATA_BITS-1:0] w_data,
  output logic                        weights_ready,
  output logic signed [DATA_BITS-1:0] data_out,
  output logic                        valid_out,
  output logic                        done
);

  logic [3:0]                  widx;
  window_t                     kernel_sh;
  window_t                     kernel;
  logic signed [DATA_BITS-1:0] bias_sh;
  logic signed [DATA_BITS-1:0] bias;

  logic accept;
  logic load_commit;
  logic reload;

  assign accept      = valid_in && weights_ready;
  assign reload      = w_load_en && (widx == LOAD_DONE);
  assign load_commit = !w_load_en && (widx == LOAD_DONE);

  // Beats fill the shadow kernel and bias; a beat after completion restarts at tap 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx    <= '0;
      bias_sh <= '0;
      for (int i = 0; i < KERNEL_TAPS; i++) kernel_sh[i] <= '0;
    end else if (w_load_en) begin
      if (widx == LOAD_DONE) begin
        kernel_sh[0] <= w_data;
        widx         <= 4'd1;
      end else if (widx == BIAS_BEAT) begin
        bias_sh <= w_data;
        widx    <= LOAD_DONE;
      end else begin
        kernel_sh[widx] <= w_data;
        widx            <= widx + 4'd1;
      end
    end
  end

  // The active kernel only changes on commit, so windows already accepted keep their coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_ready <= 1'b0;
      bias          <= '0;
      for (int i = 0; i < KERNEL_TAPS; i++) kernel[i] <= '0;
    end else if (reload) begin
      weights_ready <= 1'b0;
    end else if (load_commit) begin
      weights_ready <= 1'b1;
      kernel        <= kernel_sh;
      bias          <= bias_sh;
    end
  end

  logic signed [PROD_W-1:0]    prod_p0 [KERNEL_TAPS];
  logic signed [DATA_BITS-1:0] bias_p0;
  logic signed [SUM_W-1:0]     row_p1 [KERNEL_ROWS];
  logic signed [DATA_BITS-1:0] bias_p1;
  logic signed [DATA_BITS-1:0] result_p2;
  logic                        vld_p0;
  logic                        vld_p1;

  always_ff @(posedge clk) begin
    // S1: products
    for (int i = 0; i < KERNEL_TAPS; i++) begin
      prod_p0[i] <= PROD_W'(data_in[i]) * PROD_W'(kernel[i]);
    end
    bias_p0 <= bias;
    // S2: row sums
    for (int r = 0; r < KERNEL_ROWS; r++) begin
      row_p1[r] <= SUM_W'(prod_p0[KERNEL_ROWS*r])
                 + SUM_W'(prod_p0[KERNEL_ROWS*r+1])
                 + SUM_W'(prod_p0[KERNEL_ROWS*r+2]);
    end
    bias_p1 <= bias_p0;
  end

  // S3: round, shift, saturate
  conv1_round_sat u_round_sat (
    .row_sum (row_p1),
    .bias    (bias_p1),
    .result  (result_p2)
  );

  logic [PIX_W-1:0] pix_cnt;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(OUT_PIXELS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      pix_cnt   <= '0;
    end else begin
      vld_p0    <= accept;
      vld_p1    <= vld_p0;
      valid_out <= vld_p1;
      done      <= 1'b0;
      if (vld_p1) begin
        data_out <= result_p2;
        if (pix_cnt == PIX_LAST) begin
          pix_cnt <= '0;
          done    <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

endmodule
